// File: rtl/regfile_multiport.sv
// Multiported register file: two write ports, two combinational read ports,
// same-cycle write bypass, one write-protected constant entry, and a
// sequenced bulk clear that zeroes one entry per clock.
module regfile_multiport #(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     DEPTH    = 8,
  parameter int unsigned     AW       = 3,
  parameter int unsigned     RO_ADDR  = DEPTH - 1,
  parameter logic [WIDTH-1:0] RO_VALUE = '0,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             wr_err
);

  localparam logic [AW-1:0] RoAddr  = AW'(RO_ADDR);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {sIdle, sClear, sDone} clrState_e;

  clrState_e        state;
  logic [AW-1:0]    clrIdx;
  logic [WIDTH-1:0] mem [DEPTH];

  logic acc0_c;
  logic acc1_c;
  logic rej_c;

  // Write acceptance: idle, in range, not the protected entry
  always_comb begin
    acc0_c = we0 && (state == sIdle) && (waddr0 != RoAddr) && (32'(waddr0) < DEPTH);
    acc1_c = we1 && (state == sIdle) && (waddr1 != RoAddr) && (32'(waddr1) < DEPTH);
    rej_c  = (we0 && !acc0_c) || (we1 && !acc1_c);
  end

  // Read mux: protected entry, out of range, bypass (port 1 first), array
  function automatic logic [WIDTH-1:0] readEntry(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] val;
    val = '0;
    if (ra == RoAddr)
      val = RO_VALUE;
    else if (32'(ra) >= DEPTH)
      val = '0;
    else if (BYPASS && acc1_c && (waddr1 == ra))
      val = wdata1;
    else if (BYPASS && acc0_c && (waddr0 == ra))
      val = wdata0;
    else
      val = mem[ra];
    return val;
  endfunction

  // Combinational read ports
  always_comb begin
    rdata0 = readEntry(raddr0);
    rdata1 = readEntry(raddr1);
  end

  // Array storage, clear sequencer and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      state    <= sIdle;
      clrIdx   <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_err   <= rej_c;
      clr_done <= 1'b0;
      case (state)
        sIdle: begin
          // port 1 written last so it wins on an address collision
          if (acc0_c) mem[waddr0] <= wdata0;
          if (acc1_c) mem[waddr1] <= wdata1;
          if (clr_req) begin
            state    <= sClear;
            clrIdx   <= '0;
            clr_busy <= 1'b1;
          end
        end
        sClear: begin
          mem[clrIdx] <= '0;
          if (clrIdx == LastIdx) begin
            state    <= sDone;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clrIdx <= clrIdx + AW'(1);
          end
        end
        sDone: begin
          state <= sIdle;
        end
        default: begin
          state    <= sIdle;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: DEPTH=6 with AW=3 so that
// addresses 6 and 7 are out of range; protected entry 5 reads 0xA5.
module tb_regfile_multiport;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AW    = 3;

  logic             clk;
  logic             reset;
  logic             we0;
  logic [AW-1:0]    waddr0;
  logic [WIDTH-1:0] wdata0;
  logic             we1;
  logic [AW-1:0]    waddr1;
  logic [WIDTH-1:0] wdata1;
  logic [AW-1:0]    raddr0;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;
  logic             wr_err;

  int tests;
  int fails;
  int busyCnt;

  regfile_multiport #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .RO_ADDR (5),
    .RO_VALUE(8'hA5),
    .BYPASS  (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we0     (we0),
    .waddr0  (waddr0),
    .wdata0  (wdata0),
    .we1     (we1),
    .waddr1  (waddr1),
    .wdata1  (wdata1),
    .raddr0  (raddr0),
    .raddr1  (raddr1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .wr_err  (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    busyCnt = 0;
    reset   = 1'b1;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    raddr0 = 3'd0; raddr1 = 3'd5;
    clr_req = 1'b0;

    // reset state
    #3;
    chk("rst_rd0", 32'(rdata0), 32'h00);
    chk("rst_ro", 32'(rdata1), 32'hA5);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // single write, bypass then stored
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h5A; raddr0 = 3'd2;
    #1 chk("byp_w0", 32'(rdata0), 32'h5A);
    step();
    we0 = 1'b0;
    #1 chk("stored_a2", 32'(rdata0), 32'h5A);
    chk("err_ok_a2", 32'(wr_err), 32'd0);

    // collision: port 1 wins, no error
    we0 = 1'b1; waddr0 = 3'd3; wdata0 = 8'h11;
    we1 = 1'b1; waddr1 = 3'd3; wdata1 = 8'h22; raddr0 = 3'd3;
    #1 chk("byp_coll", 32'(rdata0), 32'h22);
    step();
    we0 = 1'b0; we1 = 1'b0;
    #1 chk("coll_a3", 32'(rdata0), 32'h22);
    chk("coll_err", 32'(wr_err), 32'd0);

    // protected entry write rejected
    we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'hFF; raddr0 = 3'd5;
    #1 chk("ro_nobyp", 32'(rdata0), 32'hA5);
    step();
    we0 = 1'b0;
    #1 chk("ro_err", 32'(wr_err), 32'd1);
    chk("ro_val", 32'(rdata0), 32'hA5);
    step();
    chk("ro_err_pulse", 32'(wr_err), 32'd0);

    // out-of-range write on port 1 rejected, read of it returns 0
    we1 = 1'b1; waddr1 = 3'd6; wdata1 = 8'h33; raddr1 = 3'd6;
    #1 chk("oor_rd", 32'(rdata1), 32'h00);
    step();
    we1 = 1'b0;
    #1 chk("oor_err", 32'(wr_err), 32'd1);

    // both ports rejected in one cycle: single pulse
    we0 = 1'b1; waddr0 = 3'd7; wdata0 = 8'h01;
    we1 = 1'b1; waddr1 = 3'd5; wdata1 = 8'h02;
    step();
    we0 = 1'b0; we1 = 1'b0;
    #1 chk("dual_rej_err", 32'(wr_err), 32'd1);
    step();
    chk("dual_rej_pulse", 32'(wr_err), 32'd0);

    // fill entries 0, 1, 4
    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'h10;
    we1 = 1'b1; waddr1 = 3'd1; wdata1 = 8'h20;
    step();
    we1 = 1'b0; waddr0 = 3'd4; wdata0 = 8'h44;
    step();
    we0 = 1'b0; raddr0 = 3'd0; raddr1 = 3'd4;
    #1 chk("fill_a0", 32'(rdata0), 32'h10);
    chk("fill_a4", 32'(rdata1), 32'h44);

    // bulk clear
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_busy_on", 32'(clr_busy), 32'd1);
    chk("clr_a0_pre", 32'(rdata0), 32'h10);
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h77; raddr1 = 3'd2;
    #1 chk("clr_nobyp", 32'(rdata1), 32'h5A);
    for (int i = 0; i < 20 && clr_busy; i++) begin
      busyCnt++;
      step();
      if (i == 0) begin
        we0 = 1'b0;
        chk("clr_wr_err", 32'(wr_err), 32'd1);
        chk("clr_a0_zero", 32'(rdata0), 32'h00);
        chk("clr_a2_kept", 32'(rdata1), 32'h5A);
      end
    end
    chk("clr_busy_cycles", 32'(busyCnt), 32'(DEPTH));
    chk("clr_done_on", 32'(clr_done), 32'd1);
    chk("clr_busy_off", 32'(clr_busy), 32'd0);
    // write in DONE is rejected
    we1 = 1'b1; waddr1 = 3'd1; wdata1 = 8'h99; raddr0 = 3'd1;
    #1 chk("done_nobyp", 32'(rdata0), 32'h00);
    step();
    we1 = 1'b0;
    #1 chk("done_pulse", 32'(clr_done), 32'd0);
    chk("done_wr_err", 32'(wr_err), 32'd1);
    chk("clr_a1", 32'(rdata0), 32'h00);
    raddr0 = 3'd3; raddr1 = 3'd4;
    #1 chk("clr_a3", 32'(rdata0), 32'h00);
    chk("clr_a4", 32'(rdata1), 32'h00);

    // writes accepted again after the clear
    we0 = 1'b1; waddr0 = 3'd1; wdata0 = 8'h3C; raddr0 = 3'd1;
    step();
    we0 = 1'b0;
    #1 chk("post_clr_a1", 32'(rdata0), 32'h3C);
    chk("post_clr_err", 32'(wr_err), 32'd0);

    // reset mid-clear abandons the sequence and zeroes everything
    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'h66;
    we1 = 1'b1; waddr1 = 3'd4; wdata1 = 8'h67;
    step();
    we0 = 1'b0; we1 = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    raddr0 = 3'd4; raddr1 = 3'd1;
    #1 chk("mid_a4_pre", 32'(rdata0), 32'h67);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(clr_busy), 32'd0);
    chk("mid_rst_a4", 32'(rdata0), 32'h00);
    chk("mid_rst_a1", 32'(rdata1), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h12; raddr0 = 3'd2;
    step();
    we0 = 1'b0;
    #1 chk("mid_idle_wr", 32'(rdata0), 32'h12);
    chk("mid_idle_err", 32'(wr_err), 32'd0);
    chk("mid_idle_done", 32'(clr_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
